// File: rtl/fft_bfly_sched_if.sv
// Control, operand-read, twiddle and write-back signals of the radix-2 butterfly scheduler.
// The hold input exists only when FFT_SCHED_STALL_EN is defined.
interface fft_bfly_sched_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_p;
    logic [7:0] rd_addr_q;
    logic [6:0] tw_addr;
    logic       bf_en;
    logic       bf_vld;
    logic       wr_en;
    logic [7:0] wr_addr_p;
    logic [7:0] wr_addr_q;
    logic [2:0] stage;
    logic       err;
`ifdef FFT_SCHED_STALL_EN
    logic       hold;

    modport master (
        input  start, bf_vld, hold,
        output busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
               wr_en, wr_addr_p, wr_addr_q, stage, err
    );
    modport slave (
        output start, bf_vld, hold,
        input  busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
               wr_en, wr_addr_p, wr_addr_q, stage, err
    );
`else
    modport master (
        input  start, bf_vld,
        output busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
               wr_en, wr_addr_p, wr_addr_q, stage, err
    );
    modport slave (
        output start, bf_vld,
        input  busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
               wr_en, wr_addr_p, wr_addr_q, stage, err
    );
`endif
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT address scheduler for a 256-point FFT (8 stages x 128 butterflies).
// Latency: first read 1 cycle after start, bf_en 1 cycle after rd_en, write-back when bf_vld returns.
// Backpressure: FFT_SCHED_STALL_EN adds hold, which freezes issue in RUN; write-back is never stalled.
module fft_bfly_sched (
    input  logic              clk,
    input  logic              rst_n,
    fft_bfly_sched_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  stage_q, stage_d;
    logic        rd_en_w, err_clr, hold_w;
    logic        err_q, bf_en_q;

`ifdef FFT_SCHED_STALL_EN
    assign hold_w = bus.hold;
`else
    assign hold_w = 1'b0;
`endif

    // Address FIFO: one {p,q} entry per issued butterfly, retired on bf_vld.
    logic [15:0] fifo_mem [8];
    logic [2:0]  wp_q, rp_q;
    logic [3:0]  cnt_q;
    logic        fifo_empty, fifo_full, push_ok, pop_ok;

    // p is k with a zero bit inserted at position stage; q sets that bit.
    logic [6:0]  lo_mask, j;
    logic [7:0]  p_calc, q_calc;
    logic [6:0]  tw_calc;
    logic [7:0]  p_last, q_last;
    logic [6:0]  tw_last;

    assign lo_mask = (7'd1 << stage_q) - 7'd1;
    assign j       = k_q & lo_mask;
    assign p_calc  = (({1'b0, k_q} >> stage_q) << ({1'b0, stage_q} + 4'd1)) | {1'b0, j};
    assign q_calc  = p_calc + (8'd1 << stage_q);
    assign tw_calc = j << (3'd7 - stage_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        rd_en_w = 1'b0;
        err_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = '0;
                    err_clr = 1'b1;
                end
            end
            RUN: begin
                if (!hold_w) begin
                    rd_en_w = 1'b1;
                    k_d     = k_q + 7'd1;
                    if (k_q == 7'd127) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    k_d = '0;
                    if (stage_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_empty = (cnt_q == 4'd0);
    assign fifo_full  = (cnt_q == 4'd8);
    assign pop_ok     = bus.bf_vld && !fifo_empty;
    assign push_ok    = rd_en_w && (!fifo_full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wp_q] <= {p_calc, q_calc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            bf_en_q <= 1'b0;
            err_q   <= 1'b0;
            p_last  <= '0;
            q_last  <= '0;
            tw_last <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 3'd1;
            if (pop_ok)  rp_q <= rp_q + 3'd1;
            cnt_q   <= cnt_q + {3'd0, push_ok} - {3'd0, pop_ok};
            bf_en_q <= rd_en_w;
            err_q   <= (err_clr ? 1'b0 : err_q)
                     | (bus.bf_vld && fifo_empty)
                     | (rd_en_w && !push_ok);
            if (rd_en_w) begin
                p_last  <= p_calc;
                q_last  <= q_calc;
                tw_last <= tw_calc;
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.stage     = stage_q;
    assign bus.err       = err_q;
    assign bus.rd_en     = rd_en_w;
    assign bus.rd_addr_p = rd_en_w ? p_calc  : p_last;
    assign bus.rd_addr_q = rd_en_w ? q_calc  : q_last;
    assign bus.tw_addr   = rd_en_w ? tw_calc : tw_last;
    assign bus.bf_en     = bf_en_q;
    assign bus.wr_en     = pop_ok;
    assign bus.wr_addr_p = pop_ok ? fifo_mem[rp_q][15:8] : 8'd0;
    assign bus.wr_addr_q = pop_ok ? fifo_mem[rp_q][7:0]  : 8'd0;
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Randomised bench for fft_bfly_sched: butterfly responder with 3-cycle return and a
// stage/butterfly reference model built from plain division and modulo arithmetic.
module tb_fft_bfly_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_bfly_sched_if bus();
    fft_bfly_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int s; int k; int p; int q; int tw; } rd_t;
    typedef struct { int p; int q; int c; } wr_t;

    rd_t exp_rd[$];
    wr_t exp_wr[$];

    int n_chk = 0, n_err = 0, cyc = 0;
    bit start_req, vld_force, rst_req, hold_req, hold_cur;
    bit [2:0] en_hist;
    bit prev_rd, m_busy, m_err, m_expect_rd;
    int stage_issued, run_issued, run_wr, run_done, start_cyc, cur_stage, cur_k;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void fill_reads();
        exp_rd.delete();
        for (int s = 0; s < 8; s++) begin
            int half = 2 ** s;
            for (int k = 0; k < 128; k++) begin
                rd_t e;
                e.s  = s;
                e.k  = k;
                e.p  = (k / half) * (2 * half) + (k % half);
                e.q  = e.p + half;
                e.tw = (k % half) * (128 / half);
                exp_rd.push_back(e);
            end
        end
    endfunction

    task automatic observe();
        int  sz0;
        bit  accept;
        rd_t e;
        wr_t w;
        if (!rst_n) begin
            chk("reset_outs", {bus.busy, bus.done, bus.rd_en, bus.bf_en, bus.wr_en, bus.err,
                               bus.stage, bus.rd_addr_p, bus.rd_addr_q, bus.tw_addr,
                               bus.wr_addr_p, bus.wr_addr_q}, 64'd0);
            exp_wr.delete();
            exp_rd.delete();
            m_busy = 0; m_err = 0; m_expect_rd = 0; prev_rd = 0;
            en_hist = {en_hist[1:0], 1'b0};
            return;
        end
        if (!m_busy) chk("rd_idle", bus.rd_en, 0);
        if (m_expect_rd) chk("rd_run", bus.rd_en, !hold_cur);
        if (stage_issued == 128 && exp_wr.size() > 0) chk("rd_drain", bus.rd_en, 0);
        chk("bf_en", bus.bf_en, prev_rd);
        prev_rd = bus.rd_en;

        sz0 = exp_wr.size();
        chk("wr_en", bus.wr_en, bus.bf_vld && sz0 > 0);
        if (bus.bf_vld && sz0 > 0) begin
            w = exp_wr.pop_front();
            chk("wr_p", bus.wr_addr_p, w.p);
            chk("wr_q", bus.wr_addr_q, w.q);
            chk("wr_lat", cyc - w.c, 4);
            run_wr++;
        end
        chk("err", bus.err, m_err);

        if (bus.rd_en) begin
            if (exp_rd.size() == 0) begin
                chk("rd_extra", bus.rd_en, 0);
            end else begin
                e = exp_rd.pop_front();
                chk("rd_p", bus.rd_addr_p, e.p);
                chk("rd_q", bus.rd_addr_q, e.q);
                chk("rd_tw", bus.tw_addr, e.tw);
                chk("rd_stage", bus.stage, e.s);
                if (e.s == 0 && e.k == 0) begin
                    chk("first_p", bus.rd_addr_p, 0);
                    chk("first_q", bus.rd_addr_q, 1);
                    chk("first_tw", bus.tw_addr, 0);
                    chk("first_lat", cyc - start_cyc, 1);
                end
                if (e.s == 0 && e.k == 1) begin
                    chk("second_p", bus.rd_addr_p, 2);
                    chk("second_q", bus.rd_addr_q, 3);
                end
                if (e.s == 1 && e.k == 1) begin
                    chk("s1k1_p", bus.rd_addr_p, 1);
                    chk("s1k1_q", bus.rd_addr_q, 3);
                    chk("s1k1_tw", bus.tw_addr, 64);
                end
                if (e.s == 7 && e.k == 5) begin
                    chk("s7k5_p", bus.rd_addr_p, 5);
                    chk("s7k5_q", bus.rd_addr_q, 133);
                    chk("s7k5_tw", bus.tw_addr, 5);
                end
                if (e.k == 0) stage_issued = 0;
                stage_issued++;
                run_issued++;
                cur_stage = e.s;
                cur_k = e.k;
                m_expect_rd = (stage_issued < 128);
                exp_wr.push_back('{p: e.p, q: e.q, c: cyc});
            end
        end

        if (bus.done) begin
            run_done++;
            chk("done_rd_left", exp_rd.size(), 0);
            chk("done_wr_left", exp_wr.size(), 0);
        end
        chk("busy", bus.busy, m_busy);

        accept = bus.start && !m_busy;
        if (bus.done) m_busy = 0;
        if (accept) begin
            fill_reads();
            m_busy = 1; m_expect_rd = 1;
            stage_issued = 0; run_issued = 0; run_wr = 0; run_done = 0;
            start_cyc = cyc;
            m_err = 0;
        end
        if (bus.bf_vld && sz0 == 0) m_err = 1;
        en_hist = {en_hist[1:0], bus.bf_en};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst_n = !rst_req;
        bus.start = start_req;
        start_req = 0;
        bus.bf_vld = en_hist[2] | vld_force;
        vld_force = 0;
        hold_cur = hold_req;
`ifdef FFT_SCHED_STALL_EN
        bus.hold = hold_req;
`endif
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic run_to_done(input int budget, input int abort_stage, input int abort_k,
                               output bit aborted);
        int hold_cnt = 0;
        bit did_hold5 = 0;
        aborted = 0;
        for (int i = 0; i < budget; i++) begin
`ifdef FFT_SCHED_STALL_EN
            if (!did_hold5 && cur_stage == 2 && stage_issued == 40 && m_expect_rd) begin
                hold_cnt = 5;
                did_hold5 = 1;
            end else if (hold_cnt == 0 && m_expect_rd && run_issued > 0 &&
                         $urandom_range(0, 39) == 0) begin
                hold_cnt = $urandom_range(1, 5);
            end
`endif
            hold_req = (hold_cnt > 0);
            if (hold_cnt > 0) hold_cnt--;
            if (m_busy && $urandom_range(0, 49) == 0) start_req = 1;
            tick();
            if (abort_stage >= 0 && bus.rd_en && cur_stage == abort_stage && cur_k == abort_k) begin
                hold_req = 0;
                rst_req = 1;
                tick();
                rst_req = 0;
                aborted = 1;
                break;
            end
            if (run_done > 0) break;
        end
        hold_req = 0;
    endtask

    bit ab;

    initial begin
        rst_n = 0;
        bus.start = 0;
        bus.bf_vld = 0;
`ifdef FFT_SCHED_STALL_EN
        bus.hold = 0;
`endif
        rst_req = 1;
        repeat (3) tick();
        rst_req = 0;
        repeat (3) tick();

        vld_force = 1;
        tick();
        tick();
        chk("err_idle", bus.err, 1);
        repeat ($urandom_range(1, 5)) tick();
        start_req = 1;
        tick();
        tick();
        chk("err_clr", bus.err, 0);
        run_to_done(3000, -1, 0, ab);
        chk("run1_done", run_done, 1);
        chk("run1_wr", run_wr, 1024);
        chk("run1_rd", run_issued, 1024);
        chk("run1_err", bus.err, 0);
        tick();
        chk("run1_idle", bus.busy, 0);

        repeat ($urandom_range(2, 8)) tick();
        start_req = 1;
        tick();
        run_to_done(3000, 3, $urandom_range(5, 120), ab);
        chk("abort_hit", ab, 1);
        chk("abort_no_done", run_done, 0);
        repeat (10) tick();
        chk("abort_busy", bus.busy, 0);
        chk("err_stale", bus.err, 1);

        start_req = 1;
        tick();
        run_to_done(3000, -1, 0, ab);
        chk("run2_done", run_done, 1);
        chk("run2_wr", run_wr, 1024);
        chk("run2_rd", run_issued, 1024);
        chk("run2_err", bus.err, 0);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fft_bfly_sched.md
FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to run a full 256-point transform.
REQ-004 SHALL have ports busy and done, output, 1 each: busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-005 SHALL have ports rd_en (output, 1), rd_addr_p (output, 8) and rd_addr_q (output, 8): the operand read request to the data RAM, which returns data 1 cycle later.
REQ-006 SHALL have port tw_addr, output, 7, the twiddle ROM index, valid with rd_en.
REQ-007 SHALL have port bf_en, output, 1, the butterfly enable, equal to rd_en delayed 1 cycle and aligned with the returned RAM and ROM data.
REQ-008 SHALL have port bf_vld, input, 1, the butterfly result-valid signal, arriving 3 cycles after bf_en.
REQ-009 SHALL have ports wr_en (output, 1), wr_addr_p (output, 8) and wr_addr_q (output, 8): the result write-back for the yp and yq results.
REQ-010 SHALL have ports stage (output, 3, the current stage 0..7) and err (output, 1, sticky protocol error).

Function
REQ-011 SHALL implement in-place radix-2 DIT scheduling: 8 stages, 128 butterflies per stage; input data is already in bit-reversed order.
REQ-012 For stage s and butterfly k, with half = 2^s and j = k mod half: SHALL output p = ((k>>s)<<(s+1)) + j, q = p + half, and tw_addr = j<<(7-s).
REQ-013 SHALL use the states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE->RUN on start; entering RUN clears stage, k and err.
REQ-015 In RUN, SHALL assert rd_en every cycle with k incrementing by 1, and issue k=0 in the cycle after start is sampled.
REQ-016 After issuing k=127, RUN SHALL go to DRAIN.
REQ-017 In DRAIN, SHALL hold rd_en low until the address FIFO is empty (all writes of the stage done).
REQ-018 On leaving DRAIN, SHALL go to RUN with stage+1 and k=0 if stage<7, otherwise to DONE.
REQ-019 DONE SHALL last 1 cycle with done=1, then return to IDLE; stage resets to 0.
REQ-020 Each rd_en SHALL push {rd_addr_p, rd_addr_q} into an 8-deep address FIFO.
REQ-021 When bf_vld=1, SHALL drive wr_en=1 combinationally with wr_addr_p/q from the FIFO head, and pop the FIFO; a simultaneous push and pop leaves the count unchanged.
REQ-022 If bf_vld=1 while the FIFO is empty, SHALL hold wr_en at 0 and set err=1.
REQ-023 A push into a full FIFO SHALL set err=1 and drop the entry.
REQ-024 SHALL ignore start while busy.
REQ-025 When rd_en=0, SHALL hold the address outputs at their last value.

Reset
REQ-026 While rst_n=0, SHALL put the FSM in IDLE, set stage=0 and k=0, empty the FIFO and pipeline, and drive busy, done, rd_en, bf_en, wr_en, err and all addresses to 0.
REQ-027 A reset mid-transform SHALL abort the transform immediately with no done pulse.
REQ-028 bf_vld after a mid-transform reset SHALL follow REQ-022.

Configuration
REQ-029 With FFT_SCHED_STALL_EN defined, SHALL add input port hold (1 bit): while hold=1 in RUN, rd_en=0 and k and stage are frozen; bf_en, bf_vld and write-back continue unaffected.
REQ-030 Without FFT_SCHED_STALL_EN, the hold port SHALL be absent and RUN SHALL issue every cycle.

Verification
REQ-031 Reset then a start pulse: the first rd_en SHALL come 1 cycle later with p=0, q=1, tw=0, and the next with p=2, q=3, tw=0; bf_en SHALL follow each rd_en by 1 cycle.
REQ-032 Stage 1, k=1: SHALL give p=1, q=3, tw=64. Stage 7, k=5: SHALL give p=5, q=133, tw=5.
REQ-033 A bench model returning bf_vld 3 cycles after bf_en: each wr_addr_p/q SHALL equal the rd_addr_p/q issued 4 cycles earlier; the transform SHALL complete with 1024 writes, one done pulse and err=0.
REQ-034 bf_vld pulsed in IDLE SHALL give wr_en=0 and err=1; a following start SHALL clear err.
REQ-035 rst_n low for 1 cycle during stage 3 SHALL force all outputs to 0 and the FSM to IDLE; a later start SHALL restart from stage 0.
REQ-036 With FFT_SCHED_STALL_EN defined, hold=1 for 5 cycles mid-stage SHALL give no rd_en for those cycles, resume at the next k, and keep the address sequence unbroken.
